// File: rtl/turbo_qpp_addr_gen_p8_pkg.sv
// Shared constants for the P8 QPP address generator: lane count, widths,
// ROM word field positions and the control FSM encoding.
package turbo_qpp_pkg;
    localparam int N_LANES       = 8;
    localparam int AW            = 13;
    localparam int ROM_WIDTH     = 70;
    localparam int ROM_ADDR_BITS = 10;
    localparam int MAX_IDX       = 564;
    localparam int INIT_CYCLES   = 7;

    localparam int K_MSB  = 69;
    localparam int K_LSB  = 57;
    localparam int F1_MSB = 56;
    localparam int F1_LSB = 48;
    localparam int F2_MSB = 47;
    localparam int F2_LSB = 39;
    localparam int A_MSB  = 38;
    localparam int A_LSB  = 26;
    localparam int B_MSB  = 25;
    localparam int B_LSB  = 13;
    localparam int C_MSB  = 12;
    localparam int C_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LOAD = 3'd2,
        ST_INIT = 3'd3,
        ST_RUN  = 3'd4
    } state_t;
endpackage

// File: rtl/turbo_qpp_addr_gen_p8_mod_add.sv
// Modular adder s = (a + b) mod k, valid when both operands are already below k.
module qpp_mod_add
    import turbo_qpp_pkg::*;
(
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic [AW-1:0] k,
    output logic [AW-1:0] s
);
    logic [AW:0] sum;
    logic [AW:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = sum - {1'b0, k};
    assign s    = (sum >= {1'b0, k}) ? diff[AW-1:0] : sum[AW-1:0];
endmodule

// File: rtl/turbo_qpp_addr_gen_p8.sv
// QPP interleaver address generator: fetches one parameter word from the ROM,
// seeds 8 window lanes, then streams natural/interleaved address beats.
module turbo_qpp_addr_gen_p8
    import turbo_qpp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROM_ADDR_BITS-1:0] k_index,
    output logic [ROM_ADDR_BITS-1:0] rom_addr,
    input  logic [ROM_WIDTH-1:0]     rom_data,
    output logic                     busy,
    output logic                     err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_LANES*AW-1:0]    out_nat,
    output logic [N_LANES*AW-1:0]    out_int,
    output logic                     out_last,
    output logic                     done
);
    state_t                   state_reg;
    logic [ROM_ADDR_BITS-1:0] rom_addr_reg;
    logic                     err_reg;
    logic                     done_reg;
    logic                     out_valid_reg;
    logic [AW-1:0]            k_reg;
    logic [AW-1:0]            b_reg;
    logic [AW-1:0]            c_reg;
    logic [AW-1:0]            d_reg;
    logic [AW-1:0]            two_f2_reg;
    logic [9:0]               w_reg;
    logic [9:0]               i_reg;
    logic [2:0]               init_cnt_reg;

    logic [AW-1:0] pi_arr [N_LANES];
    logic [AW-1:0] g_arr  [N_LANES];

    logic [AW-1:0] rom_k, rom_f1, rom_f2, rom_a, rom_b, rom_c;
    logic [2:0]    init_prev;
    logic [AW-1:0] sh_a0, sh_b0, sh_a1, sh_b1, sh_k;
    logic [AW-1:0] sh_s0, sh_s1, sh_s2;
    logic          beat_accept;

    assign rom_k  = rom_data[K_MSB:K_LSB];
    assign rom_f1 = {{(AW-9){1'b0}}, rom_data[F1_MSB:F1_LSB]};
    assign rom_f2 = {{(AW-9){1'b0}}, rom_data[F2_MSB:F2_LSB]};
    assign rom_a  = rom_data[A_MSB:A_LSB];
    assign rom_b  = rom_data[B_MSB:B_LSB];
    assign rom_c  = rom_data[C_MSB:C_LSB];

    assign init_prev   = init_cnt_reg - 3'd1;
    assign beat_accept = (state_reg == ST_RUN) && out_valid_reg && out_ready;

    // LOAD reuses the INIT adders: adder0 gives g0=(f1+f2) mod K, adder1 gives 2f2 mod K.
    always_comb begin
        sh_a0 = pi_arr[init_prev];
        sh_b0 = d_reg;
        sh_a1 = g_arr[init_prev];
        sh_b1 = c_reg;
        sh_k  = k_reg;
        if (state_reg == ST_LOAD) begin
            sh_a0 = rom_f1;
            sh_b0 = rom_f2;
            sh_a1 = rom_f2;
            sh_b1 = rom_f2;
            sh_k  = rom_k;
        end
    end

    qpp_mod_add u_add_pi (.a(sh_a0), .b(sh_b0), .k(sh_k),  .s(sh_s0));
    qpp_mod_add u_add_g  (.a(sh_a1), .b(sh_b1), .k(sh_k),  .s(sh_s1));
    qpp_mod_add u_add_d  (.a(d_reg), .b(b_reg), .k(k_reg), .s(sh_s2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rom_addr_reg  <= '0;
            err_reg       <= 1'b0;
            done_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            k_reg         <= '0;
            b_reg         <= '0;
            c_reg         <= '0;
            d_reg         <= '0;
            two_f2_reg    <= '0;
            w_reg         <= '0;
            i_reg         <= '0;
            init_cnt_reg  <= '0;
        end else begin
            err_reg  <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (k_index != '0 && k_index <= ROM_ADDR_BITS'(MAX_IDX)) begin
                            rom_addr_reg <= k_index;
                            state_reg    <= ST_WAIT;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_WAIT: state_reg <= ST_LOAD;
                ST_LOAD: begin
                    k_reg        <= rom_k;
                    w_reg        <= rom_k[AW-1:3];
                    b_reg        <= rom_b;
                    c_reg        <= rom_c;
                    d_reg        <= rom_a;
                    two_f2_reg   <= sh_s1;
                    i_reg        <= '0;
                    init_cnt_reg <= 3'd1;
                    state_reg    <= ST_INIT;
                end
                ST_INIT: begin
                    d_reg        <= sh_s2;
                    init_cnt_reg <= init_cnt_reg + 3'd1;
                    if (init_cnt_reg == 3'(INIT_CYCLES)) begin
                        state_reg     <= ST_RUN;
                        out_valid_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (beat_accept) begin
                        if (i_reg == w_reg - 10'd1) begin
                            out_valid_reg <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end else begin
                            i_reg <= i_reg + 10'd1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [AW-1:0] pi_reg, g_reg;
            logic [AW-1:0] pi_next, g_next;

            qpp_mod_add u_run_pi (.a(pi_reg), .b(g_reg),      .k(k_reg), .s(pi_next));
            qpp_mod_add u_run_g  (.a(g_reg),  .b(two_f2_reg), .k(k_reg), .s(g_next));

            always_ff @(posedge clk) begin
                if (rst) begin
                    pi_reg <= '0;
                    g_reg  <= '0;
                end else if (state_reg == ST_LOAD && gi == 0) begin
                    pi_reg <= '0;
                    g_reg  <= sh_s0;
                end else if (state_reg == ST_INIT && init_cnt_reg == 3'(gi)) begin
                    pi_reg <= sh_s0;
                    g_reg  <= sh_s1;
                end else if (beat_accept) begin
                    pi_reg <= pi_next;
                    g_reg  <= g_next;
                end
            end

            assign pi_arr[gi] = pi_reg;
            assign g_arr[gi]  = g_reg;
            assign out_int[gi*AW +: AW] = pi_reg;
            assign out_nat[gi*AW +: AW] = AW'(gi) * {{(AW-10){1'b0}}, w_reg}
                                        + {{(AW-10){1'b0}}, i_reg};
        end
    endgenerate

    assign rom_addr  = rom_addr_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign err       = err_reg;
    assign done      = done_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_valid_reg && (i_reg == w_reg - 10'd1);
endmodule

// File: tb/tb_turbo_qpp_addr_gen_p8.sv
// Directed bench for turbo_qpp_addr_gen_p8 with a registered parameter-ROM model
// and a direct pi(x) = (f1*x + f2*x^2) mod K reference.
module tb_turbo_qpp_addr_gen_p8;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [9:0]   k_index;
    logic [9:0]   rom_addr;
    logic [69:0]  rom_data;
    logic         busy, err, out_valid, out_ready, out_last, done;
    logic [103:0] out_nat, out_int;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    turbo_qpp_addr_gen_p8 dut (
        .clk(clk), .rst(rst), .start(start), .k_index(k_index),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .out_nat(out_nat),
        .out_int(out_int), .out_last(out_last), .done(done)
    );

    // Synthetic table: idx1 matches the documented K=40 entry, idx564 is the K=6144 corner.
    function automatic int k_of(input int idx);
        return (idx == 564) ? 6144 : 40 + 8 * (idx - 1);
    endfunction
    function automatic int f1_of(input int idx);
        return (idx == 1) ? 3 : (2 * idx + 1) % 512;
    endfunction
    function automatic int f2_of(input int idx);
        return (idx == 1) ? 10 : (6 * idx + 4) % 512;
    endfunction

    function automatic logic [69:0] rom_word(input logic [9:0] a);
        longint k, f1, f2, w, av, bv, cv;
        logic [69:0] word;
        word = '0;
        if (a != 0 && a <= 564) begin
            k  = k_of(int'(a));
            f1 = f1_of(int'(a));
            f2 = f2_of(int'(a));
            w  = k / 8;
            av = (f1 * w + f2 * w * w) % k;
            bv = (2 * f2 * w * w) % k;
            cv = (2 * f2 * w) % k;
            word = {k[12:0], f1[8:0], f2[8:0], av[12:0], bv[12:0], cv[12:0]};
        end
        return word;
    endfunction

    function automatic longint pi_ref(input int idx, input longint x);
        longint k, f1, f2;
        k  = k_of(idx);
        f1 = f1_of(idx);
        f2 = f2_of(idx);
        return (f1 * x + f2 * x * x) % k;
    endfunction

    always_ff @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One block: start, latency check, per-beat lane checks, done check.
    // abort_beat >= 0 asserts rst at that beat and verifies everything clears.
    task automatic run_block(input int idx, input bit rnd, input bit poke, input int abort_beat);
        int n, w, beat, guard;
        bit accepted;
        int hand_lane0 [5] = '{0, 13, 6, 19, 12};
        int hand_int0 [3]  = '{0, 25, 30};
        int hand_nat0 [3]  = '{0, 5, 10};
        w = k_of(idx) / 8;
        @(negedge clk);
        start = 1'b1;
        k_index = 10'(idx);
        out_ready = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
        end while (!out_valid && n < 40);
        check("first_beat_cycle", n, 10);

        beat = 0;
        guard = 0;
        while (beat < w && guard < 8 * w + 50) begin
            guard++;
            if (beat == abort_beat) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("rst_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_err", err, 0);
                check("rst_last", out_last, 0);
                check("rst_rom_addr", rom_addr, 0);
                check("rst_nat", out_nat[63:0], 0);
                check("rst_int", out_int[63:0], 0);
                check("rst_int_hi", out_int[103:64], 0);
                rst = 1'b0;
                $display("block idx=%0d aborted by reset at beat %0d", idx, beat);
                return;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && beat == 1) begin
                start = 1'b1;
                k_index = 10'd0;
            end else begin
                start = 1'b0;
            end
            check("valid", out_valid, 1);
            check("busy_run", busy, 1);
            check("err_quiet", err, 0);
            check("rom_addr_held", rom_addr, idx);
            check($sformatf("last b%0d", beat), out_last, (beat == w - 1) ? 1 : 0);
            for (int l = 0; l < 8; l++) begin
                check($sformatf("nat[%0d] b%0d", l, beat), out_nat[l*13 +: 13], l * w + beat);
                check($sformatf("int[%0d] b%0d", l, beat), out_int[l*13 +: 13], pi_ref(idx, l * w + beat));
            end
            if (idx == 1) begin
                check($sformatf("hand_lane0 b%0d", beat), out_int[12:0], hand_lane0[beat]);
                if (beat == 0) begin
                    for (int l = 0; l < 3; l++) begin
                        check($sformatf("hand_int[%0d]", l), out_int[l*13 +: 13], hand_int0[l]);
                        check($sformatf("hand_nat[%0d]", l), out_nat[l*13 +: 13], hand_nat0[l]);
                    end
                end
            end
            @(posedge clk);
            accepted = out_ready && out_valid;
            @(negedge clk);
            if (accepted) beat++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("beat_budget", beat, w);
        check("done_pulse", done, 1);
        check("valid_drop", out_valid, 0);
        @(negedge clk);
        check("done_clear", done, 0);
        check("busy_idle", busy, 0);
        check("err_after", err, 0);
        $display("block idx=%0d K=%0d beats=%0d ready=%s", idx, k_of(idx), beat, rnd ? "random" : "high");
    endtask

    task automatic bad_start(input int idx, input int addr_exp);
        @(negedge clk);
        start = 1'b1;
        k_index = 10'(idx);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_rom_addr", rom_addr, addr_exp);
        @(negedge clk);
        check("err_clear", err, 0);
        check("err_busy2", busy, 0);
        $display("bad start idx=%0d rejected", idx);
    endtask

    initial begin
        int sweep [7] = '{2, 3, 50, 200, 401, 563, 564};
        rst = 1'b1;
        start = 1'b0;
        k_index = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        check("reset_done", done, 0);
        check("reset_rom_addr", rom_addr, 0);
        check("reset_nat", out_nat[63:0], 0);
        check("reset_int", out_int[63:0], 0);
        rst = 1'b0;

        run_block(1, 1'b0, 1'b0, -1);
        run_block(1, 1'b1, 1'b0, -1);
        bad_start(0, 1);
        bad_start(565, 1);
        bad_start(1023, 1);
        run_block(1, 1'b0, 1'b0, 2);
        run_block(1, 1'b0, 1'b0, -1);
        for (int s = 0; s < 7; s++)
            run_block(sweep[s], 1'(s % 2), 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
